// File: rtl/tl_arb_pkg.sv
// Shared types and helpers for the TileLink round-robin burst arbiter.
// Holds the lock-state enum, the requester ceiling and a one-hot encoder.
package tl_arb_pkg;

  localparam int MAX_N = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  function automatic logic [MAX_N-1:0] onehot(
    input int idx,
    input int n
  );
    logic [MAX_N-1:0] r;
    r = '0;
    if (idx >= 0 && idx < n) r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating find-first: first set request at or after ptr, wrapping mod N.
// Purely combinational so an idle grant costs no cycle.
module rr_priority_pick #(
  parameter int N = 3,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] pick,
  output logic          any
);

  always_comb begin
    pick = ptr;
    any  = 1'b0;
    // Walk from the far end so the nearest hit wins.
    for (int k = N - 1; k >= 0; k--) begin
      automatic int idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        pick = PW'(idx);
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tl_rr_burst_arbiter.sv
// Round-robin arbiter granting whole multi-beat bursts onto one channel.
// Idle grant is combinational; the lock holds the owner until its last beat.
module tl_rr_burst_arbiter
  import tl_arb_pkg::*;
#(
  parameter int N = 3,
  parameter int W = 32,
  localparam int PW = $clog2(N)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [N-1:0]   in_last,
  input  logic [N*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_last,
  output logic [W-1:0]   out_data,
  output logic [N-1:0]   out_sel,
  output logic           busy
);

  state_e        state_q, state_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [7:0]    beats_q, beats_d;
  logic [PW-1:0] pick, sel_idx;
  logic          any, fire;

  rr_priority_pick #(.N(N)) u_pick (
    .req  (in_valid),
    .ptr  (ptr_q),
    .pick (pick),
    .any  (any)
  );

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (int'(p) == N - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    sel_idx   = pick;
    out_sel   = '0;
    out_valid = 1'b0;
    if (state_q == LOCKED) begin
      sel_idx   = owner_q;
      out_sel   = N'(onehot(int'(owner_q), N));
      out_valid = in_valid[owner_q];
    end else if (any) begin
      out_sel   = N'(onehot(int'(pick), N));
      out_valid = 1'b1;
    end
    out_data = (|out_sel) ? in_data[int'(sel_idx)*W +: W] : '0;
    out_last = (|out_sel) ? in_last[sel_idx] : 1'b0;
    in_ready = {N{out_ready}} & out_sel;
    fire     = out_valid & out_ready;
    busy     = (state_q == LOCKED);
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    beats_d = beats_q;
    if (fire && beats_q != 8'hFF) beats_d = beats_q + 8'd1;
    unique case (state_q)
      IDLE: begin
        if (out_valid) begin
          if (fire && out_last) begin
            ptr_d = wrap_inc(pick);
          end else begin
            state_d = LOCKED;
            owner_d = pick;
          end
        end
      end
      LOCKED: begin
        if (fire && out_last) begin
          state_d = IDLE;
          ptr_d   = wrap_inc(owner_q);
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) beats_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      beats_q <= beats_d;
    end
  end

endmodule

// File: tb/tb_tl_rr_burst_arbiter.sv
// Self-checking bench for tl_rr_burst_arbiter: directed scenarios plus
// random traffic against a burst-level round-robin reference model.
module tb_tl_rr_burst_arbiter;

  localparam int N = 3;
  localparam int W = 32;

  logic           clock;
  logic           reset;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N-1:0]   in_last;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;
  logic [W-1:0]   out_data;
  logic [N-1:0]   out_sel;
  logic           busy;

  tl_rr_burst_arbiter #(.N(N), .W(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 when free) and rotation start.
  int m_owner;
  int m_ptr;
  int cur_burst;
  int last_sel;
  bit last_fire;
  bit last_last;
  logic [N-1:0] obs_sel, obs_rdy;
  logic         obs_busy, obs_valid;
  logic [W-1:0] obs_data;

  task automatic model_reset();
    m_owner   = -1;
    m_ptr     = 0;
    cur_burst = -1;
  endtask

  task automatic model_pick(output int s, output bit v);
    s = -1;
    v = 1'b0;
    if (m_owner >= 0) begin
      s = m_owner;
      v = in_valid[s];
    end else begin
      for (int k = 0; k < N; k++) begin
        if (s < 0 && in_valid[(m_ptr + k) % N]) s = (m_ptr + k) % N;
      end
      v = (s >= 0);
    end
  endtask

  task automatic tick();
    int s;
    bit v;
    logic [N-1:0] es;
    @(negedge clock);
    model_pick(s, v);
    es = '0;
    if (s >= 0) es[s] = 1'b1;
    check("sel", out_sel, es);
    check("valid", out_valid, v);
    check("in_ready", in_ready, out_ready ? es : '0);
    check("data", out_data, (s >= 0) ? in_data[s*W +: W] : '0);
    check("last", out_last, (s >= 0) ? in_last[s] : 1'b0);
    check("busy", busy, m_owner >= 0);
    check("onehot", $countones(out_sel) <= 1, 1);
    obs_sel   = out_sel;
    obs_rdy   = in_ready;
    obs_busy  = busy;
    obs_valid = out_valid;
    obs_data  = out_data;
    last_sel  = s;
    last_fire = v && out_ready;
    last_last = (s >= 0) && in_last[s];
    @(posedge clock);
    if (last_fire) begin
      if (cur_burst >= 0) check("interleave", last_sel, cur_burst);
      cur_burst = last_last ? -1 : last_sel;
    end
    if (m_owner < 0) begin
      if (v) begin
        if (last_fire && last_last) m_ptr = (s + 1) % N;
        else m_owner = s;
      end
    end else if (last_fire && last_last) begin
      m_owner = -1;
      m_ptr   = (s + 1) % N;
    end
    #1;
  endtask

  task automatic do_reset();
    in_valid  = '0;
    in_last   = '0;
    out_ready = 1'b0;
    reset     = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  int rem[N];
  int wait_n[N];
  bit waiting[N];
  logic [N-1:0] seq[6];

  initial begin
    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100;
    seq[3] = 3'b001; seq[4] = 3'b010; seq[5] = 3'b100;
    in_data = '0;
    model_reset();

    // Reset with no requests
    in_valid  = '0;
    in_last   = '0;
    out_ready = 1'b1;
    reset     = 1'b1;
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_sel", out_sel, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick();
    check("idle_sel", obs_sel, 0);

    // All valid, single-beat bursts: strict rotation
    do_reset();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'h1000 + i;
    in_valid  = 3'b111;
    in_last   = 3'b111;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rr_seq", obs_sel, seq[k]);
    end

    // Four-beat burst on req1 with req0/req2 contending
    do_reset();
    out_ready = 1'b1;
    in_valid  = 3'b001;
    in_last   = 3'b001;
    tick();
    in_valid = 3'b111;
    in_last  = 3'b101;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) in_last = 3'b111;
      tick();
      check("burst_sel", obs_sel, 3'b010);
      check("burst_busy", obs_busy, k != 0);
    end
    tick();
    check("after_burst", obs_sel, 3'b100);
    check("after_busy", obs_busy, 0);

    // Stalled first beat on req0 holds selection and data
    do_reset();
    in_data[0*W +: W] = 32'hA5A5_0000;
    in_valid  = 3'b001;
    in_last   = 3'b001;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) in_valid = 3'b011;
      tick();
      check("stall_sel", obs_sel, 3'b001);
      check("stall_data", obs_data, 32'hA5A5_0000);
    end
    out_ready = 1'b1;
    tick();
    check("stall_fire", obs_rdy, 3'b001);
    in_valid = 3'b010;
    tick();
    check("stall_next", obs_sel, 3'b010);

    // Owner req2 drops valid mid-burst while req0 waits
    do_reset();
    out_ready = 1'b1;
    in_valid  = 3'b100;
    in_last   = 3'b000;
    tick();
    in_valid = 3'b001;
    in_last  = 3'b001;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("gap_valid", obs_valid, 0);
      check("gap_sel", obs_sel, 3'b100);
      check("gap_rdy0", obs_rdy[0], 0);
    end
    in_valid = 3'b101;
    in_last  = 3'b101;
    tick();
    check("resume_sel", obs_sel, 3'b100);
    in_valid = 3'b001;
    tick();
    check("resume_next", obs_sel, 3'b001);

    // Asynchronous reset in the middle of a locked burst
    do_reset();
    out_ready = 1'b1;
    in_valid  = 3'b001;
    in_last   = 3'b001;
    tick();
    in_valid = 3'b100;
    in_last  = 3'b000;
    tick();
    @(negedge clock);
    check("pre_rst_busy", busy, 1);
    in_valid = '0;
    reset    = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ptr", dut.ptr_q, 0);
    check("mid_rst_beats", dut.beats_q, 0);
    check("mid_rst_valid", out_valid, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    tick();
    check("post_rst_busy", obs_busy, 0);

    // Random traffic
    do_reset();
    for (int i = 0; i < N; i++) begin
      rem[i]     = 0;
      wait_n[i]  = 0;
      waiting[i] = 1'b0;
    end
    for (int c = 0; c < 10000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!in_valid[i]) begin
          if (rem[i] == 0) begin
            if ($urandom_range(0, 2) == 0) begin
              rem[i]     = $urandom_range(1, 4);
              in_valid[i] = 1'b1;
              waiting[i] = 1'b1;
              wait_n[i]  = 0;
              in_data[i*W +: W] = $urandom();
            end
          end else if ($urandom_range(0, 1) == 0) begin
            in_valid[i] = 1'b1;
          end
        end
        in_last[i] = (rem[i] == 1);
      end
      tick();
      if (last_fire) begin
        automatic int j = last_sel;
        waiting[j] = 1'b0;
        rem[j]--;
        if (last_last) begin
          for (int i = 0; i < N; i++) begin
            if (i != j && waiting[i]) begin
              wait_n[i]++;
              check("fair", wait_n[i] > N, 0);
            end
          end
        end
        if (rem[j] == 0) begin
          in_valid[j] = 1'b0;
        end else begin
          in_valid[j] = ($urandom_range(0, 3) != 0);
          in_data[j*W +: W] = $urandom();
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
